// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcode constants, canonical NOP and fetch-stage state encoding.
package rv32i_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC select: hold, sequential +4, or word-aligned redirect.
// next_pc is combinational so the fetch FSM can launch a request on the same edge pc updates.
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        advance,
  input  logic [31:0] base_pc,
  output logic [31:0] next_pc,
  output logic        misalign_err
);

  logic [31:0] pc;

  // Redirect beats sequential advance; low bits are cleared rather than trapped.
  always_comb begin
    next_pc = pc;
    if (redirect_valid) begin
      next_pc = {redirect_pc[31:2], 2'b00};
    end else if (advance) begin
      next_pc = base_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      pc           <= next_pc;
      misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: one outstanding imem request, 2-cycle best-case issue rate.
// Holds the presented instruction under stall; responses made stale by a redirect are drained and dropped.
module instr_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  output logic        misalign_err
);

  fetch_state_t state, next_state;
  logic [31:0]  req_addr;
  logic [31:0]  next_pc;
  logic         load_req;
  logic         capture;
  logic         advance;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (advance),
    .base_pc        (inst_pc),
    .next_pc        (next_pc),
    .misalign_err   (misalign_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load_req   = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        next_state = FETCH;
        load_req   = 1'b1;
      end
      FETCH: begin
        if (imem_ack && !redirect_valid) begin
          capture    = 1'b1;
          next_state = VALID;
        end else if (imem_ack) begin
          load_req = 1'b1;
        end else if (redirect_valid) begin
          next_state = DRAIN;
        end
      end
      // The old request must still complete; the target already sits in pc.
      DRAIN: begin
        if (imem_ack) begin
          next_state = FETCH;
          load_req   = 1'b1;
        end
      end
      VALID: begin
        if (redirect_valid) begin
          next_state = FETCH;
          load_req   = 1'b1;
        end else if (!stall) begin
          advance    = 1'b1;
          next_state = FETCH;
          load_req   = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr <= RESET_PC;
      inst     <= RV32I_NOP;
      inst_pc  <= RESET_PC;
    end else begin
      if (load_req) begin
        req_addr <= next_pc;
      end
      if (capture) begin
        inst    <= imem_rdata;
        inst_pc <= req_addr;
      end
    end
  end

  assign imem_req   = (state == FETCH) || (state == DRAIN);
  assign imem_addr  = req_addr;
  assign inst_valid = (state == VALID);
  assign opcode     = inst[6:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Fetch-unit bench: transaction-level model of requests, stale responses and presented instructions.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic        misalign_err;

  int n_checks = 0;
  int n_errors = 0;

  int mem_lat = 0;
  int mem_wait = 0;
  bit mem_busy = 1'b0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .opcode         (opcode),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0020_81B3;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0033;
  endfunction

  // Applies one cycle of inputs (memory reply follows imem_req), then lands at posedge+1.
  task automatic drive(input logic rv, input logic [31:0] rpc, input logic st);
    redirect_valid = rv;
    redirect_pc    = rpc;
    stall          = st;
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_wait = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
      end
      if (mem_wait == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        mem_busy   = 1'b0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        mem_wait--;
      end
    end else begin
      imem_ack = 1'b0;
      mem_busy = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Reference model: next fetch address, the open request, and the instruction being presented.
  logic [31:0] m_exp_pc, m_req_addr, m_live_inst, m_live_pc;
  bit m_open, m_stale, m_live, m_idle, m_mis;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_exp_pc = 32'h0; m_open = 0; m_stale = 0; m_live = 0; m_idle = 1; m_mis = 0;
      m_req_addr = 32'h0; m_live_inst = 32'h0; m_live_pc = 32'h0;
    end else begin
      chk("misalign", 32'(misalign_err), 32'(m_mis));
      chk("valid", 32'(inst_valid), 32'(m_live));
      if (m_live) begin
        chk("inst", inst, m_live_inst);
        chk("inst_pc", inst_pc, m_live_pc);
        chk("opcode", 32'(opcode), 32'(m_live_inst[6:0]));
      end
      chk("req", 32'(imem_req), 32'(!m_live && !m_idle));
      if (imem_req) begin
        if (m_open) chk("addr_hold", imem_addr, m_req_addr);
        else begin
          chk("req_addr", imem_addr, m_exp_pc);
          m_open = 1; m_stale = 0; m_req_addr = m_exp_pc;
        end
      end
      m_idle = 0;
      m_mis  = redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        m_exp_pc = redirect_pc & 32'hFFFF_FFFC;
        if (m_open) m_stale = 1;
        m_live = 0;
      end else if (m_live && !stall) begin
        m_live   = 0;
        m_exp_pc = m_live_pc + 32'd4;
      end
      if (imem_req && imem_ack) begin
        if (!m_stale) begin
          m_live = 1; m_live_inst = imem_rdata; m_live_pc = m_req_addr;
        end
        m_open = 0;
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'h0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_valid"}, 32'(inst_valid), 32'h0);
    chk({tag, "_inst"}, inst, 32'h0000_0013);
    chk({tag, "_pc"}, inst_pc, 32'h0);
    chk({tag, "_opc"}, 32'(opcode), 32'(7'b0010011));
    chk({tag, "_mis"}, 32'(misalign_err), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // Zero-latency memory: 0x0 then 0x4, first instruction two cycles after release.
    mem_lat = 0;
    drive(0, 0, 0);
    chk("first_req", 32'(imem_req), 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    drive(0, 0, 0);
    chk("lat_valid", 32'(inst_valid), 32'h1);
    chk("lat_opcode", 32'(opcode), 32'(7'b0110011));

    // Stall three cycles in VALID.
    drive(0, 0, 1);
    drive(0, 0, 1);
    drive(0, 0, 1);
    chk("stall_inst", inst, 32'h0020_81B3);
    chk("stall_pc", inst_pc, 32'h0);
    chk("stall_req", 32'(imem_req), 32'h0);
    drive(0, 0, 0);
    chk("stall_next_req", 32'(imem_req), 32'h1);
    chk("stall_next_addr", imem_addr, 32'h4);

    // Redirect while 0x8 is pending with 3-cycle ack.
    mem_lat = 3;
    for (int i = 0; i < 20 && !(imem_req && imem_addr == 32'h8 && !mem_busy); i++) drive(0, 0, 0);
    chk("wait_req8", 32'(imem_req && imem_addr == 32'h8), 32'h1);
    drive(1, 32'h100, 0);
    chk("drain_req", 32'(imem_req), 32'h1);
    chk("drain_addr", imem_addr, 32'h8);
    for (int i = 0; i < 10 && !(imem_req && imem_addr == 32'h100); i++) drive(0, 0, 0);
    chk("after_drain_addr", imem_addr, 32'h100);

    // Redirect with stall in VALID.
    mem_lat = 1;
    for (int i = 0; i < 20 && !inst_valid; i++) drive(0, 0, 0);
    chk("wait_valid_d", 32'(inst_valid), 32'h1);
    drive(1, 32'h40, 1);
    chk("rs_valid", 32'(inst_valid), 32'h0);
    chk("rs_addr", imem_addr, 32'h40);

    // Misaligned redirect.
    for (int i = 0; i < 20 && !inst_valid; i++) drive(0, 0, 0);
    drive(1, 32'h102, 0);
    chk("mis_pulse", 32'(misalign_err), 32'h1);
    chk("mis_addr", imem_addr, 32'h100);
    drive(0, 0, 0);
    chk("mis_clear", 32'(misalign_err), 32'h0);

    // PC wrap.
    for (int i = 0; i < 20 && !inst_valid; i++) drive(0, 0, 0);
    drive(1, 32'hFFFF_FFFC, 0);
    for (int i = 0; i < 20 && !inst_valid; i++) drive(0, 0, 0);
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    drive(0, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);

    // Random traffic.
    mem_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 1023));
      drive($urandom_range(0, 7) == 0, tgt, $urandom_range(0, 2) == 0);
    end

    // Asynchronous reset mid-request.
    for (int i = 0; i < 20 && !imem_req; i++) drive(0, 0, 0);
    chk("wait_req_rst", 32'(imem_req), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("arst");
    mem_busy = 1'b0;
    imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) drive(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the RV32I single-cycle core: owns the program counter, issues word requests to instruction memory over a req/ack handshake, and presents each fetched instruction, its PC and its opcode field to the control unit and decoder. It accepts PC redirects from branch/jump resolution and holds its output while downstream stalls. Outstanding memory responses made stale by a redirect are dropped.

## Interface
- RESET_PC, 32'h0000_0000, PC value fetched first after reset; bits [1:0] must be 0
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request; held high until imem_ack
- imem_addr  out  32  word-aligned fetch address; stable while imem_req=1 and ack not yet seen
- imem_ack  in  1  response strobe; imem_rdata is valid in the same cycle
- imem_rdata  in  32  instruction word
- redirect_valid  in  1  one-cycle strobe: branch taken or jump
- redirect_pc  in  32  redirect target
- stall  in  1  downstream cannot accept the presented instruction
- inst_valid  out  1  inst/inst_pc/opcode hold a live instruction
- inst  out  32  fetched instruction
- inst_pc  out  32  address of inst
- opcode  out  7  inst[6:0]; drives the control unit
- misalign_err  out  1  one-cycle pulse on a redirect with redirect_pc[1:0]≠0

## Operation
- States: IDLE, FETCH, VALID, DRAIN.
- IDLE: entered only from reset. imem_req=0. Moves to FETCH on the next edge.
- FETCH: imem_req=1, imem_addr=req_addr. req_addr is loaded from pc when FETCH is entered.
  - ack without redirect: capture inst=imem_rdata and inst_pc=req_addr, then go to VALID.
  - ack with redirect in the same cycle: discard the data, set pc=redirect target, stay in FETCH with the new req_addr.
  - redirect without ack: set pc=redirect target, go to DRAIN.
- DRAIN: imem_req stays 1 with the old req_addr until ack. The response is discarded, then go to FETCH at the new pc. Further redirects while in DRAIN overwrite pc; the last one wins.
- VALID: inst_valid=1.
  - redirect: drop the instruction, set pc=redirect target, go to FETCH. Redirect has priority over stall.
  - no redirect and stall=0: instruction consumed, pc=inst_pc+4, go to FETCH.
  - stall=1: hold all outputs unchanged.
- Redirect target is redirect_pc with bits [1:0] forced to 00. If the original bits [1:0]≠0, misalign_err pulses in the following cycle.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- inst_valid is 0 in IDLE, FETCH and DRAIN. inst/inst_pc keep their last value there.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=RESET_PC, opcode=7'b0010011, misalign_err=0, state=IDLE.
- Reset asserted mid-request abandons the transaction immediately. Any ack after reset release while in IDLE is ignored.
- Fetch latency: from entering FETCH with ack in the same cycle, inst_valid rises on the next edge.
- Best-case throughput is one instruction per 2 cycles (FETCH, VALID).
- Redirect penalty is 0 extra cycles in VALID, and drain time plus 1 cycle in FETCH.
- opcode is a combinational slice of the inst register; there is no extra delay.

## Structure
- Shared package rv32i_pkg holds:
  - opcode constants OPC_RTYPE=0110011, OPC_ITYPE=0010011, OPC_LOAD=0000011, OPC_STORE=0100011, OPC_BRANCH=1100011, OPC_LUI=0110111, OPC_JAL=1101111
  - RV32I_NOP=32'h0000_0013
  - fetch state enum
- Sub-module pc_reg: PC register plus next-PC mux (hold / +4 / redirect with alignment clear and misalign detect).

## Test plan
- Reset release, memory acks in the same cycle: address 0x0 then 0x4 are requested. inst_valid rises 2 cycles after release with inst=imem data and opcode=0110011 for 32'h0020_81B3.
- stall=1 for 3 cycles in VALID: inst/inst_pc are unchanged, imem_req=0 throughout. Fetch of pc+4 starts the cycle after stall drops.
- Redirect to 0x100 while a request to 0x8 is pending with a 3-cycle ack: DRAIN holds imem_addr=0x8 until ack, the data is never presented, and the next request is 0x100.
- Redirect in VALID together with stall=1: the instruction is dropped, the next imem_addr is the target, and inst_valid=0.
- Redirect to 0x102: fetch goes to 0x100 and misalign_err is high for exactly 1 cycle.
- Sequential fetch from inst_pc=0xFFFF_FFFC: the next imem_addr is 0x0000_0000. rst_n pulled low mid-request returns all outputs to their reset values asynchronously.
